io_out_port: RTL and testbench

Output-port block of the single-cycle core: the write-direction counterpart of the register-file write-back input path. When decode issues an output operation, the register-file read value is captured, buffered in a small FIFO, and presented to the external peripheral over a valid/ready handshake. The core is stalled only when the buffer is full.

---
 rtl/riscv_io_pkg.sv | 13 +
 rtl/io_out_port_if.sv | 30 +++
 rtl/io_out_fifo.sv | 59 +++++
 rtl/io_out_port.sv | 85 ++++++++
 tb/tb_io_out_port.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_io_pkg.sv
// Shared definitions for the core's I/O port blocks: default widths/depths
// and the output-stage state encoding.
package riscv_io_pkg;

  localparam int IO_DATA_W     = 32;
  localparam int IO_FIFO_DEPTH = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_out_port_if.sv
// Bundle between decode/register file, the output port and the peripheral.
// The slave modport is the output port's view; master is the surrounding system.
interface io_out_port_if
  import riscv_io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
);
  localparam int OCC_W = $clog2(DEPTH + 1) + 1;

  logic [DATA_W-1:0] rf_data;
  logic              io_out_en;
  logic              io_out_stall;
  logic [DATA_W-1:0] io_data;
  logic              io_valid;
  logic              io_ready;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow;

  modport master (
    output rf_data, io_out_en, io_ready,
    input  io_out_stall, io_data, io_valid, occupancy, overflow
  );

  modport slave (
    input  rf_data, io_out_en, io_ready,
    output io_out_stall, io_data, io_valid, occupancy, overflow
  );

endinterface

// File: rtl/io_out_fifo.sv
// Circular buffer feeding the output register. The head is read
// combinationally so the output stage can load it in the same cycle it pops.
module io_out_fifo
  import riscv_io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_out_port.sv
// Output port: buffers words issued by decode and presents them to the
// peripheral over valid/ready, stalling the core only when the FIFO is full.
module io_out_port
  import riscv_io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
) (
  input logic          clk,
  input logic          rst,
  io_out_port_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 1) + 1;

  out_state_e        state_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              overflow_reg;

  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              out_full;
  logic              transfer;
  logic              can_load;
  logic              fifo_pop;
  logic              bypass;
  logic              fifo_push;
  logic              drop;

  assign out_full  = (state_reg == OUT_FULL);
  assign transfer  = out_full && bus.io_ready;
  assign can_load  = !out_full || transfer;
  // Buffered words always take priority over the incoming word to keep order.
  assign fifo_pop  = can_load && !fifo_empty;
  assign bypass    = can_load && fifo_empty && bus.io_out_en;
  assign fifo_push = bus.io_out_en && !bypass && !fifo_full;
  assign drop      = bus.io_out_en && !bypass && fifo_full;

  io_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (bus.rf_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= OUT_EMPTY;
      out_data_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (fifo_pop) begin
        out_data_reg <= fifo_head;
        state_reg    <= OUT_FULL;
      end else if (bypass) begin
        out_data_reg <= bus.rf_data;
        state_reg    <= OUT_FULL;
      end else if (transfer) begin
        state_reg    <= OUT_EMPTY;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.io_valid     = out_full;
  assign bus.io_data      = out_data_reg;
  assign bus.io_out_stall = fifo_full;
  assign bus.overflow     = overflow_reg;
  assign bus.occupancy    = OCC_W'(fifo_count) + OCC_W'(out_full);

endmodule

// File: tb/tb_io_out_port.sv
// Directed bench for io_out_port: reset, latency, fill/stall, overflow,
// streaming, randomised handshake with scoreboard, and mid-transfer reset.
module tb_io_out_port;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  io_out_port_if #(.DATA_W(32), .DEPTH(4)) bus ();

  io_out_port #(.DATA_W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sb[$];
    logic [31:0] held;
    logic        hold_chk;
    logic [31:0] w;
    int          pushes;
    int          cyc;

    rst = 1'b1;
    bus.rf_data = '0;
    bus.io_out_en = 1'b0;
    bus.io_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(bus.io_valid), 32'd0);
    check("rst_data", bus.io_data, 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_stall", 32'(bus.io_out_stall), 32'd0);

    // Single push, one-cycle latency, then drained.
    bus.io_ready = 1'b1;
    bus.io_out_en = 1'b1;
    bus.rf_data = 32'hDEADBEEF;
    step();
    bus.io_out_en = 1'b0;
    check("single_valid", 32'(bus.io_valid), 32'd1);
    check("single_data", bus.io_data, 32'hDEADBEEF);
    check("single_occ", 32'(bus.occupancy), 32'd1);
    step();
    check("single_drain_valid", 32'(bus.io_valid), 32'd0);
    check("single_drain_occ", 32'(bus.occupancy), 32'd0);

    // Fill with peripheral not ready.
    bus.io_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.io_out_en = 1'b1;
      bus.rf_data = 32'(i);
      step();
      check("fill_data_held", bus.io_data, 32'd1);
      check("fill_valid", 32'(bus.io_valid), 32'd1);
      check("fill_occ", 32'(bus.occupancy), 32'(i));
      check("fill_stall", 32'(bus.io_out_stall), (i == 5) ? 32'd1 : 32'd0);
    end

    // Push into a full buffer is dropped.
    bus.rf_data = 32'h99;
    step();
    bus.io_out_en = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_occ", 32'(bus.occupancy), 32'd5);
    check("ovf_data_held", bus.io_data, 32'd1);

    // Drain in order.
    bus.io_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("drain_valid", 32'(bus.io_valid), 32'd1);
      check("drain_data", bus.io_data, 32'(i));
      step();
      if (i == 1) check("drain_stall_clear", 32'(bus.io_out_stall), 32'd0);
    end
    check("drain_empty", 32'(bus.io_valid), 32'd0);
    check("drain_occ", 32'(bus.occupancy), 32'd0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Streaming: one word per cycle.
    for (int i = 16; i <= 31; i++) begin
      bus.io_out_en = 1'b1;
      bus.rf_data = 32'(i);
      step();
      check("stream_valid", 32'(bus.io_valid), 32'd1);
      check("stream_data", bus.io_data, 32'(i));
      check("stream_stall", 32'(bus.io_out_stall), 32'd0);
    end
    bus.io_out_en = 1'b0;
    step();
    check("stream_end_valid", 32'(bus.io_valid), 32'd0);

    // Randomised handshake against a scoreboard.
    pushes = 0;
    hold_chk = 1'b0;
    held = '0;
    cyc = 0;
    while ((pushes < 100 || sb.size() != 0) && cyc < 3000) begin
      bus.io_ready = (pushes >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.io_out_en = (pushes < 100) && !bus.io_out_stall && ($urandom_range(0, 3) != 0);
      w = $urandom;
      bus.rf_data = w;
      if (bus.io_valid && bus.io_ready) begin
        if (sb.size() == 0) begin
          check("rand_unexpected", bus.io_data, 32'hFFFF_FFFF ^ bus.io_data);
        end else begin
          check("rand_order", bus.io_data, sb.pop_front());
        end
      end
      hold_chk = bus.io_valid && !bus.io_ready;
      held = bus.io_data;
      if (bus.io_out_en) begin
        sb.push_back(w);
        pushes++;
      end
      step();
      if (hold_chk) begin
        check("rand_hold_valid", 32'(bus.io_valid), 32'd1);
        check("rand_hold_data", bus.io_data, held);
      end
      cyc++;
    end
    bus.io_out_en = 1'b0;
    check("rand_pushes_done", 32'(pushes), 32'd100);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    step();
    check("rand_end_valid", 32'(bus.io_valid), 32'd0);

    // Reset with three words buffered, during a transfer.
    bus.io_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.io_out_en = 1'b1;
      bus.rf_data = 32'h100 + 32'(i);
      step();
    end
    bus.io_out_en = 1'b0;
    check("pre_rst_occ", 32'(bus.occupancy), 32'd3);
    bus.io_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.io_ready = 1'b0;
    check("midrst_valid", 32'(bus.io_valid), 32'd0);
    check("midrst_occ", 32'(bus.occupancy), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    check("midrst_stall", 32'(bus.io_out_stall), 32'd0);
    check("midrst_data", bus.io_data, 32'd0);
    bus.io_out_en = 1'b1;
    bus.rf_data = 32'hA5;
    step();
    bus.io_out_en = 1'b0;
    check("post_rst_data", bus.io_data, 32'hA5);
    check("post_rst_occ", 32'(bus.occupancy), 32'd1);
    bus.io_ready = 1'b1;
    step();
    check("post_rst_drain_valid", 32'(bus.io_valid), 32'd0);
    check("post_rst_drain_occ", 32'(bus.occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
